// File: rtl/mux_2to1_pkg.sv
// Shared constants for the registered 2:1 multiplexer element.
package mux_2to1_pkg;

    localparam int MUX_WIDTH_DEFAULT = 1;

    localparam logic SEL_LANE0 = 1'b0;
    localparam logic SEL_LANE1 = 1'b1;

endpackage

// File: rtl/mux_2to1_sync_if.sv
// Data/select bundle of mux_2to1_sync: two packed lanes and a select in, one registered lane out.
interface mux_2to1_sync_if #(
    parameter int WIDTH = 1
) ();

    logic [2*WIDTH-1:0] a;
    logic               b;
    logic               in_valid;
    logic [WIDTH-1:0]   c;
    logic               out_valid;

    modport master (
        output a,
        output b,
        output in_valid,
        input  c,
        input  out_valid
    );

    modport slave (
        input  a,
        input  b,
        input  in_valid,
        output c,
        output out_valid
    );

endinterface

// File: rtl/mux_2to1_core.sv
// Purely combinational lane select: y = b ? upper lane : lower lane.
module mux_2to1_core
    import mux_2to1_pkg::*;
#(
    parameter int WIDTH = MUX_WIDTH_DEFAULT
) (
    input  logic [2*WIDTH-1:0] a,
    input  logic               b,
    output logic [WIDTH-1:0]   y
);

    // An unknown select makes the ternary merge both lanes, so X propagates in simulation.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        assign y[gi] = (b == SEL_LANE0) ? a[gi] : a[WIDTH + gi];
    end

endmodule

// File: rtl/mux_2to1_sync.sv
// Registered 2:1 multiplexer: selected lane and valid flag appear one clock after acceptance.
module mux_2to1_sync
    import mux_2to1_pkg::*;
#(
    parameter int WIDTH = MUX_WIDTH_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    mux_2to1_sync_if.slave  bus
);

    if (WIDTH < 1) begin : g_width_check
        $error("mux_2to1_sync: WIDTH must be >= 1");
    end

    logic [WIDTH-1:0] w_sel;
    logic [WIDTH-1:0] r_c;
    logic             r_out_valid;

    mux_2to1_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a (bus.a),
        .b (bus.b),
        .y (w_sel)
    );

    // Reset wins over a simultaneous sample; idle cycles keep the last result on c.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_c         <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_c <= w_sel;
            end
        end
    end

    assign bus.c         = r_c;
    assign bus.out_valid = r_out_valid;

    a_no_valid_after_rst : assert property (@(posedge clk) rst |=> !bus.out_valid)
        else $error("mux_2to1_sync: out_valid high in the cycle after reset");

    a_hold_when_idle : assert property (@(posedge clk) (!rst && !bus.in_valid) |=> $stable(bus.c))
        else $error("mux_2to1_sync: c changed without an accepted sample");

    a_sel_known : assert property (@(posedge clk) disable iff (rst) bus.in_valid |-> !$isunknown(bus.b))
        else $error("mux_2to1_sync: select is X/Z while in_valid is high");

endmodule

// File: tb/tb_mux_2to1_sync.sv
// Directed and randomised checks of mux_2to1_sync at WIDTH 1, 8 and 4.
module tb_mux_2to1_sync;

    logic clk;
    logic rst1;
    logic rst8;
    logic rst4;

    int checks;
    int errors;

    mux_2to1_sync_if #(.WIDTH(1)) if1 ();
    mux_2to1_sync_if #(.WIDTH(8)) if8 ();
    mux_2to1_sync_if #(.WIDTH(4)) if4 ();

    mux_2to1_sync #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst1), .bus(if1));
    mux_2to1_sync #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst8), .bus(if8));
    mux_2to1_sync #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst4), .bus(if4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Truth table at WIDTH=1: index = {a[1], a[0], b}; expected c = a[b].
    logic [1:0] tt_a   [8] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b11, 2'b11};
    logic       tt_b   [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic       tt_exp [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    logic [7:0] ra;
    logic       rb;
    logic       riv;
    logic       rrst;
    logic [3:0] exp_c;
    logic       exp_ov;

    initial begin
        checks = 0;
        errors = 0;
        rst1 = 1'b1;
        rst8 = 1'b1;
        rst4 = 1'b1;
        if1.a = '0; if1.b = 1'b0; if1.in_valid = 1'b0;
        if8.a = '0; if8.b = 1'b0; if8.in_valid = 1'b0;
        if4.a = '0; if4.b = 1'b0; if4.in_valid = 1'b0;
        tick();

        // 1. Reset has priority over a presented sample
        if1.a = 2'b11; if1.b = 1'b1; if1.in_valid = 1'b1;
        tick();
        check("reset_c", 16'(if1.c), 16'h0);
        check("reset_ov", 16'(if1.out_valid), 16'h0);
        $display("reset: c=%0h out_valid=%0b", if1.c, if1.out_valid);

        // 2. Truth table sweep, one accept per cycle
        rst1 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if1.a = tt_a[i]; if1.b = tt_b[i]; if1.in_valid = 1'b1;
            tick();
            check($sformatf("tt%0d_c", i), 16'(if1.c), 16'(tt_exp[i]));
            check($sformatf("tt%0d_ov", i), 16'(if1.out_valid), 16'h1);
            $display("tt a=%b b=%b: c=%0b out_valid=%0b", tt_a[i], tt_b[i], if1.c, if1.out_valid);
        end

        // 3. Hold while idle
        if1.a = 2'b10; if1.b = 1'b1; if1.in_valid = 1'b1;
        tick();
        check("hold_accept_c", 16'(if1.c), 16'h1);
        $display("hold accept: c=%0b out_valid=%0b", if1.c, if1.out_valid);
        if1.a = 2'b00; if1.b = 1'b0; if1.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("hold%0d_c", i), 16'(if1.c), 16'h1);
            check($sformatf("hold%0d_ov", i), 16'(if1.out_valid), 16'h0);
            $display("hold idle %0d: c=%0b out_valid=%0b", i, if1.c, if1.out_valid);
        end

        // 4. Wide lanes, back-to-back
        rst8 = 1'b0;
        if8.a = 16'hA55A; if8.b = 1'b0; if8.in_valid = 1'b1;
        tick();
        check("wide_lo_c", 16'(if8.c), 16'h5A);
        check("wide_lo_ov", 16'(if8.out_valid), 16'h1);
        $display("wide b=0: c=%0h out_valid=%0b", if8.c, if8.out_valid);
        if8.b = 1'b1;
        tick();
        check("wide_hi_c", 16'(if8.c), 16'hA5);
        check("wide_hi_ov", 16'(if8.out_valid), 16'h1);
        $display("wide b=1: c=%0h out_valid=%0b", if8.c, if8.out_valid);
        if8.in_valid = 1'b0;
        tick();
        check("wide_idle_c", 16'(if8.c), 16'hA5);
        check("wide_idle_ov", 16'(if8.out_valid), 16'h0);
        $display("wide idle: c=%0h out_valid=%0b", if8.c, if8.out_valid);

        // 5. Reset in the middle of a stream
        if8.a = 16'h1234; if8.b = 1'b0; if8.in_valid = 1'b1;
        tick();
        check("mid_pre_c", 16'(if8.c), 16'h34);
        $display("mid pre: c=%0h out_valid=%0b", if8.c, if8.out_valid);
        rst8 = 1'b1; if8.a = 16'h5678;
        tick();
        check("mid_rst_c", 16'(if8.c), 16'h0);
        check("mid_rst_ov", 16'(if8.out_valid), 16'h0);
        $display("mid rst: c=%0h out_valid=%0b", if8.c, if8.out_valid);
        rst8 = 1'b0; if8.b = 1'b1;
        tick();
        check("mid_post_c", 16'(if8.c), 16'h56);
        check("mid_post_ov", 16'(if8.out_valid), 16'h1);
        $display("mid post: c=%0h out_valid=%0b", if8.c, if8.out_valid);
        if8.in_valid = 1'b0;

        // 6. Random traffic against a one-cycle-delayed reference
        exp_c = 4'h0;
        exp_ov = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            ra   = 8'($urandom);
            rb   = 1'($urandom);
            riv  = ($urandom_range(0, 3) != 0);
            rrst = ($urandom_range(0, 19) == 0);
            if (i == 0) rrst = 1'b0;
            rst4 = rrst; if4.a = ra; if4.b = rb; if4.in_valid = riv;
            if (rrst) begin
                exp_c = 4'h0;
                exp_ov = 1'b0;
            end else if (riv) begin
                exp_c = rb ? ra[7:4] : ra[3:0];
                exp_ov = 1'b1;
            end else begin
                exp_ov = 1'b0;
            end
            tick();
            check($sformatf("rnd%0d_c", i), 16'(if4.c), 16'(exp_c));
            check($sformatf("rnd%0d_ov", i), 16'(if4.out_valid), 16'(exp_ov));
            $display("rnd %0d rst=%0b iv=%0b a=%h b=%0b: c=%h out_valid=%0b",
                     i, rrst, riv, ra, rb, if4.c, if4.out_valid);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
